// File: rtl/rob_commit_pkg.sv
// Shared definitions for the reorder buffer: sizes, reserved tag/register
// numbers and the 1..DEPTH pointer wrap helper.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 31;
    localparam int TAG_W     = 5;
    localparam int REG_W     = 6;
    localparam int DATA_W    = 32;

    // Tag 0 means "value already lives in the register file".
    localparam logic [TAG_W-1:0] NO_TAG    = 5'd0;
    localparam logic [TAG_W-1:0] FIRST_TAG = 5'd1;

    // Register 32 names HI/LO; register 0 means the instruction has no destination.
    localparam logic [REG_W-1:0] REG_HILO  = 6'd32;
    localparam logic [REG_W-1:0] REG_NONE  = 6'd0;

    // Advance a ROB pointer; the last slot wraps to 1 so tag 0 is never produced.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_W'(ROB_DEPTH)) ? FIRST_TAG : t + TAG_W'(1);
    endfunction

endpackage

// File: rtl/rob_commit_ptr.sv
// Wrapping ROB pointer that lives in 1..DEPTH; used for both head and tail.
module rob_commit_ptr
    import rob_commit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [TAG_W-1:0] ptr_o
);

    logic [TAG_W-1:0] ptr_q;
    logic [TAG_W-1:0] ptr_d;

    // Next pointer: clear returns to the first live tag, inc steps with wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = FIRST_TAG;
        end else if (inc_i) begin
            ptr_d = next_tag(ptr_q);
        end
    end

    // Pointer register; reset places it on the first live tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= FIRST_TAG;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: hands out tags at issue, captures CDB results, retires
// entries in program order and answers operand value lookups by tag.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_req,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  j_tag,
    input  logic [TAG_W-1:0]  k_tag,
    output logic              j_ready,
    output logic              k_ready,
    output logic [DATA_W-1:0] j_value,
    output logic [DATA_W-1:0] k_value,
    output logic              commit_valid,
    output logic              result_wr,
    output logic [REG_W-1:0]  result_wr_reg_no,
    output logic [DATA_W-1:0] result_wr_value,
    output logic [TAG_W-1:0]  result_wr_tag,
    output logic [TAG_W:0]    count
);

    // Slot 0 exists only so tags index the arrays directly; it is never busy.
    logic [ROB_DEPTH:0] busy_q, busy_d;
    logic [ROB_DEPTH:0] done_q, done_d;
    logic [REG_W-1:0]   dest_q  [0:ROB_DEPTH];
    logic [DATA_W-1:0]  value_q [0:ROB_DEPTH];
    logic [TAG_W:0]     count_q, count_d;

    logic [TAG_W-1:0]   head;
    logic [TAG_W-1:0]   tail;
    logic               alloc_fire;
    logic               commit_fire;
    logic               wb_fire;
    logic               j_hit;
    logic               k_hit;

    rob_commit_ptr u_head (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .inc_i   (commit_fire),
        .ptr_o   (head)
    );

    rob_commit_ptr u_tail (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .inc_i   (alloc_fire),
        .ptr_o   (tail)
    );

    // Handshakes; a flush blocks allocation, commit and CDB capture for its cycle.
    assign alloc_ready  = (count_q < (TAG_W+1)'(ROB_DEPTH)) & ~flush;
    assign alloc_tag    = tail;
    assign alloc_fire   = alloc_req & alloc_ready;
    assign commit_valid = busy_q[head] & done_q[head] & ~flush;
    assign commit_fire  = commit_valid;
    assign wb_fire      = cdb_valid & ~flush & busy_q[cdb_tag];

    assign result_wr        = commit_valid & (dest_q[head] != REG_NONE);
    assign result_wr_reg_no = dest_q[head];
    assign result_wr_value  = value_q[head];
    assign result_wr_tag    = head;
    assign count            = count_q;

    // Operand lookup: a live CDB broadcast wins over a value already held in the ROB.
    assign j_hit   = cdb_valid & (cdb_tag == j_tag) & (j_tag != NO_TAG);
    assign k_hit   = cdb_valid & (cdb_tag == k_tag) & (k_tag != NO_TAG);
    assign j_ready = j_hit | (busy_q[j_tag] & done_q[j_tag]);
    assign k_ready = k_hit | (busy_q[k_tag] & done_q[k_tag]);
    assign j_value = j_hit ? cdb_value : value_q[j_tag];
    assign k_value = k_hit ? cdb_value : value_q[k_tag];

    // Entry status update; commit clears after writeback so a retiring slot ends idle.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (flush) begin
            busy_d = '0;
            done_d = '0;
        end else begin
            if (wb_fire) begin
                done_d[cdb_tag] = 1'b1;
            end
            if (commit_fire) begin
                busy_d[head] = 1'b0;
                done_d[head] = 1'b0;
            end
            if (alloc_fire) begin
                busy_d[tail] = 1'b1;
                done_d[tail] = 1'b0;
            end
        end
    end

    // Occupancy counter: allocate and commit in one cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (alloc_fire && !commit_fire) begin
            count_d = count_q + (TAG_W+1)'(1);
        end else if (commit_fire && !alloc_fire) begin
            count_d = count_q - (TAG_W+1)'(1);
        end
    end

    // Status and count registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Payload storage; left unreset since busy/done gate every use of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (alloc_fire) begin
                dest_q[tail] <= alloc_dest;
            end
            if (wb_fire) begin
                value_q[cdb_tag] <= cdb_value;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus a randomized run against an
// in-order queue model of the reorder buffer.
module tb_rob_commit;
    import rob_commit_pkg::*;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              alloc_req;
    logic [REG_W-1:0]  alloc_dest;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [TAG_W-1:0]  j_tag;
    logic [TAG_W-1:0]  k_tag;
    logic              j_ready;
    logic              k_ready;
    logic [DATA_W-1:0] j_value;
    logic [DATA_W-1:0] k_value;
    logic              commit_valid;
    logic              result_wr;
    logic [REG_W-1:0]  result_wr_reg_no;
    logic [DATA_W-1:0] result_wr_value;
    logic [TAG_W-1:0]  result_wr_tag;
    logic [TAG_W:0]    count;

    int checks   = 0;
    int failures = 0;

    rob_commit dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .alloc_req        (alloc_req),
        .alloc_dest       (alloc_dest),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_value        (cdb_value),
        .j_tag            (j_tag),
        .k_tag            (k_tag),
        .j_ready          (j_ready),
        .k_ready          (k_ready),
        .j_value          (j_value),
        .k_value          (k_value),
        .commit_valid     (commit_valid),
        .result_wr        (result_wr),
        .result_wr_reg_no (result_wr_reg_no),
        .result_wr_value  (result_wr_value),
        .result_wr_tag    (result_wr_tag),
        .count            (count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: instructions in program order, oldest at the front.
    typedef struct {
        int          tag;
        int          dest;
        bit          done;
        logic [31:0] value;
    } ent_t;

    ent_t mq[$];
    int   mTail = 1;

    logic              expReady, expCommit, expWr, expJ, expK;
    logic [TAG_W-1:0]  expTag, expCTag;
    logic [TAG_W:0]    expCount;
    logic [REG_W-1:0]  expRegNo;
    logic [DATA_W-1:0] expValue, expJVal, expKVal;

    task automatic model_lookup(input int tag, output logic rdy, output logic [31:0] val);
        rdy = 1'b0;
        val = '0;
        if (cdb_valid && int'(cdb_tag) == tag && tag != 0) begin
            rdy = 1'b1;
            val = cdb_value;
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == tag && mq[i].done) begin
                    rdy = 1'b1;
                    val = mq[i].value;
                end
            end
        end
    endtask

    task automatic model_expect();
        expReady  = (mq.size() < ROB_DEPTH) && !flush;
        expTag    = TAG_W'(mTail);
        expCount  = (TAG_W+1)'(mq.size());
        expCommit = !flush && mq.size() > 0 && mq[0].done;
        expWr     = expCommit && mq[0].dest != 0;
        if (mq.size() > 0) begin
            expRegNo = REG_W'(mq[0].dest);
            expValue = mq[0].value;
            expCTag  = TAG_W'(mq[0].tag);
        end
        model_lookup(int'(j_tag), expJ, expJVal);
        model_lookup(int'(k_tag), expK, expKVal);
    endtask

    task automatic model_edge();
        bit doCommit;
        bit doAlloc;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            mTail = 1;
            return;
        end
        doCommit = mq.size() > 0 && mq[0].done;
        doAlloc  = alloc_req && mq.size() < ROB_DEPTH;
        if (cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].tag == int'(cdb_tag)) begin
                    mq[i].done  = 1'b1;
                    mq[i].value = cdb_value;
                end
            end
        end
        if (doCommit) void'(mq.pop_front());
        if (doAlloc) begin
            e.tag   = mTail;
            e.dest  = int'(alloc_dest);
            e.done  = 1'b0;
            e.value = 'x;
            mq.push_back(e);
            mTail = (mTail == ROB_DEPTH) ? 1 : mTail + 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; alloc_req = 0; alloc_dest = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0; j_tag = '0; k_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        j_tag = 5'd1; k_tag = 5'd2;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_alloc_ready: got %0b want 1", alloc_ready); end
        checks++; if (alloc_tag !== 5'd1) begin failures++; $display("[TB] FAIL reset_alloc_tag: got %0d want 1", alloc_tag); end
        checks++; if (count !== 6'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        checks++; if (commit_valid !== 1'b0 || result_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit: got cv=%0b wr=%0b want 0/0", commit_valid, result_wr); end
        checks++; if (j_ready !== 1'b0 || k_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_lookup: got j=%0b k=%0b want 0/0", j_ready, k_ready); end
    endtask

    task automatic test_alloc_commit();
        do_reset();
        alloc_req = 1; alloc_dest = 6'd5;
        #1;
        checks++; if (alloc_tag !== 5'd1) begin failures++; $display("[TB] FAIL alloc_first_tag: got %0d want 1", alloc_tag); end
        tick();
        #1;
        checks++; if (alloc_tag !== 5'd2) begin failures++; $display("[TB] FAIL alloc_second_tag: got %0d want 2", alloc_tag); end
        tick();
        alloc_req = 0;
        #1;
        checks++; if (count !== 6'd2 || commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL alloc_count: got count=%0d cv=%0b want 2/0", count, commit_valid); end
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'hDEADBEEF;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL commit_same_cycle_cdb: got %0b want 0", commit_valid); end
        tick();
        cdb_valid = 0;
        #1;
        checks++;
        if (commit_valid !== 1'b1 || result_wr !== 1'b1 || result_wr_reg_no !== 6'd5 ||
            result_wr_value !== 32'hDEADBEEF || result_wr_tag !== 5'd1) begin
            failures++;
            $display("[TB] FAIL commit_first: got cv=%0b wr=%0b reg=%0d val=%h tag=%0d want 1/1/5/deadbeef/1",
                     commit_valid, result_wr, result_wr_reg_no, result_wr_value, result_wr_tag);
        end
        tick();
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_req = 1; alloc_dest = 6'd7; tick();
        alloc_dest = 6'd8; tick();
        alloc_req = 0;
        cdb_valid = 1; cdb_tag = 5'd2; cdb_value = 32'hAAAA0002;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL ooo_cdb2: got cv=%0b want 0", commit_valid); end
        tick();
        cdb_valid = 0;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL ooo_wait_head: got cv=%0b want 0", commit_valid); end
        tick();
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'hBBBB0001;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL ooo_cdb_head: got cv=%0b want 0", commit_valid); end
        tick();
        cdb_valid = 0;
        #1;
        checks++;
        if (commit_valid !== 1'b1 || result_wr_tag !== 5'd1 || result_wr_value !== 32'hBBBB0001 || result_wr_reg_no !== 6'd7) begin
            failures++;
            $display("[TB] FAIL ooo_commit1: got cv=%0b tag=%0d val=%h reg=%0d want 1/1/bbbb0001/7",
                     commit_valid, result_wr_tag, result_wr_value, result_wr_reg_no);
        end
        tick();
        #1;
        checks++;
        if (commit_valid !== 1'b1 || result_wr_tag !== 5'd2 || result_wr_value !== 32'hAAAA0002 || result_wr_reg_no !== 6'd8) begin
            failures++;
            $display("[TB] FAIL ooo_commit2: got cv=%0b tag=%0d val=%h reg=%0d want 1/2/aaaa0002/8",
                     commit_valid, result_wr_tag, result_wr_value, result_wr_reg_no);
        end
        tick();
        #1;
        checks++; if (commit_valid !== 1'b0 || count !== 6'd0) begin failures++; $display("[TB] FAIL ooo_empty: got cv=%0b count=%0d want 0/0", commit_valid, count); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        alloc_req = 1;
        for (int i = 1; i <= ROB_DEPTH; i++) begin
            alloc_dest = REG_W'(i);
            tick();
        end
        cdb_valid = 1; cdb_tag = 5'd1; cdb_value = 32'h0000_1111;
        #1;
        checks++; if (alloc_ready !== 1'b0 || count !== 6'd31) begin failures++; $display("[TB] FAIL full_state: got ready=%0b count=%0d want 0/31", alloc_ready, count); end
        tick();
        cdb_valid = 0;
        #1;
        checks++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_commit: got cv=%0b ready=%0b want 1/0", commit_valid, alloc_ready); end
        tick();
        alloc_dest = REG_HILO;
        #1;
        checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 5'd1 || count !== 6'd30) begin failures++; $display("[TB] FAIL wrap_tag: got ready=%0b tag=%0d count=%0d want 1/1/30", alloc_ready, alloc_tag, count); end
        tick();
        alloc_req = 0;
        #1;
        checks++; if (count !== 6'd31 || alloc_tag !== 5'd2) begin failures++; $display("[TB] FAIL wrap_refill: got count=%0d tag=%0d want 31/2", count, alloc_tag); end
    endtask

    task automatic test_lookup();
        do_reset();
        alloc_req = 1;
        for (int i = 1; i <= 3; i++) begin
            alloc_dest = REG_W'(i);
            tick();
        end
        alloc_req = 0;
        j_tag = 5'd3; k_tag = 5'd0;
        cdb_valid = 1; cdb_tag = 5'd3; cdb_value = 32'hC0FFEE03;
        #1;
        checks++; if (j_ready !== 1'b1 || j_value !== 32'hC0FFEE03) begin failures++; $display("[TB] FAIL lookup_cdb_hit: got rdy=%0b val=%h want 1/c0ffee03", j_ready, j_value); end
        checks++; if (k_ready !== 1'b0) begin failures++; $display("[TB] FAIL lookup_k_tag0: got %0b want 0", k_ready); end
        tick();
        cdb_valid = 0; k_tag = 5'd2;
        #1;
        checks++; if (j_ready !== 1'b1 || j_value !== 32'hC0FFEE03 || k_ready !== 1'b0) begin failures++; $display("[TB] FAIL lookup_rob: got j=%0b val=%h k=%0b want 1/c0ffee03/0", j_ready, j_value, k_ready); end
        cdb_valid = 1; cdb_tag = 5'd0; j_tag = 5'd0;
        #1;
        checks++; if (j_ready !== 1'b0) begin failures++; $display("[TB] FAIL lookup_j_tag0: got %0b want 0", j_ready); end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        alloc_req = 1; alloc_dest = 6'd9;
        for (int i = 0; i < 10; i++) tick();
        alloc_req = 0;
        cdb_valid = 1;
        for (int t = 2; t <= 4; t++) begin
            cdb_tag = TAG_W'(t); cdb_value = 32'h5000_0000 + t;
            tick();
        end
        cdb_tag = 5'd1; cdb_value = 32'h5000_0001;
        tick();
        flush = 1; cdb_tag = 5'd5; cdb_value = 32'h5000_0005;
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || commit_valid !== 1'b0 || result_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_cycle: got ready=%0b cv=%0b wr=%0b want 0/0/0", alloc_ready, commit_valid, result_wr);
        end
        tick();
        flush = 0; cdb_valid = 0;
        #1;
        checks++;
        if (count !== 6'd0 || alloc_tag !== 5'd1 || commit_valid !== 1'b0 || result_wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_after: got count=%0d tag=%0d cv=%0b wr=%0b want 0/1/0/0", count, alloc_tag, commit_valid, result_wr);
        end
        tick();
        #1;
        checks++; if (result_wr !== 1'b0 || commit_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_later: got cv=%0b wr=%0b want 0/0", commit_valid, result_wr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush      = ($urandom_range(0, 63) == 0);
            alloc_req  = ($urandom_range(0, 9) < 6);
            alloc_dest = REG_W'($urandom_range(0, 32));
            cdb_valid  = ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                cdb_tag = TAG_W'($urandom_range(0, 31));
            cdb_value = $urandom;
            j_tag = ($urandom_range(0, 1) == 1) ? cdb_tag : TAG_W'($urandom_range(0, 31));
            k_tag = TAG_W'($urandom_range(0, 31));
            model_expect();
            #1;
            checks++; if (alloc_ready !== expReady) begin failures++; $display("[TB] FAIL rnd_alloc_ready c%0d: got %0b want %0b", cyc, alloc_ready, expReady); end
            checks++; if (alloc_tag !== expTag) begin failures++; $display("[TB] FAIL rnd_alloc_tag c%0d: got %0d want %0d", cyc, alloc_tag, expTag); end
            checks++; if (count !== expCount) begin failures++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", cyc, count, expCount); end
            checks++; if (commit_valid !== expCommit) begin failures++; $display("[TB] FAIL rnd_commit_valid c%0d: got %0b want %0b", cyc, commit_valid, expCommit); end
            checks++; if (result_wr !== expWr) begin failures++; $display("[TB] FAIL rnd_result_wr c%0d: got %0b want %0b", cyc, result_wr, expWr); end
            if (expCommit) begin
                checks++;
                if (result_wr_reg_no !== expRegNo || result_wr_value !== expValue || result_wr_tag !== expCTag) begin
                    failures++;
                    $display("[TB] FAIL rnd_commit_data c%0d: got reg=%0d val=%h tag=%0d want %0d/%h/%0d",
                             cyc, result_wr_reg_no, result_wr_value, result_wr_tag, expRegNo, expValue, expCTag);
                end
            end
            checks++; if (j_ready !== expJ) begin failures++; $display("[TB] FAIL rnd_j_ready c%0d: got %0b want %0b", cyc, j_ready, expJ); end
            if (expJ) begin
                checks++; if (j_value !== expJVal) begin failures++; $display("[TB] FAIL rnd_j_value c%0d: got %h want %h", cyc, j_value, expJVal); end
            end
            checks++; if (k_ready !== expK) begin failures++; $display("[TB] FAIL rnd_k_ready c%0d: got %0b want %0b", cyc, k_ready, expK); end
            if (expK) begin
                checks++; if (k_value !== expKVal) begin failures++; $display("[TB] FAIL rnd_k_value c%0d: got %h want %h", cyc, k_value, expKVal); end
            end
            tick();
        end
        idle();
    endtask

    // Run every scenario in order, then report.
    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_alloc_commit();
        test_out_of_order();
        test_full_wrap();
        test_lookup();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
